// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with valid/ready backpressure and bubble collapsing.
// Define PIPE_STAGE_CHAIN_SKID_EN to add a registered-ready skid slot ahead of slot 0.
module pipe_stage_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1,
   parameter int OCC_W = $clog2(DEPTH+2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [OCC_W-1:0] occupancy
);

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] dat [DEPTH];
   logic             src_vld;
   logic [WIDTH-1:0] src_dat;
   logic             push;
   logic             pop;

   // A slot loads when it is empty or its own beat moves on.
   always_comb begin
      logic run;
      adv = '0;
      run = out_ready | ~vld[DEPTH-1];
      adv[DEPTH-1] = run;
      for (int k = DEPTH-2; k >= 0; k--) begin
         run = run | ~vld[k];
         adv[k] = run;
      end
   end

`ifdef PIPE_STAGE_CHAIN_SKID_EN
   logic             skid_vld;
   logic [WIDTH-1:0] skid_dat;

   assign in_ready = ~skid_vld & ~flush;
   assign src_vld  = skid_vld | in_valid;
   assign src_dat  = skid_vld ? skid_dat : in_data;

   // A parked beat always drains before new input is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (flush) begin
         skid_vld <= 1'b0;
      end else if (skid_vld) begin
         if (adv[0]) skid_vld <= 1'b0;
      end else if (in_valid && !adv[0]) begin
         skid_vld <= 1'b1;
         skid_dat <= in_data;
      end
   end
`else
   assign in_ready = adv[0] & ~flush;
   assign src_vld  = in_valid;
   assign src_dat  = in_data;
`endif

   assign out_valid = vld[DEPTH-1] & ~flush;
   assign out_data  = dat[DEPTH-1];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int k = 0; k < DEPTH; k++) dat[k] <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         if (adv[0]) begin
            vld[0] <= src_vld;
            if (src_vld) dat[0] <= src_dat;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) dat[k] <= dat[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occupancy <= '0;
      end else if (push && !pop) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (pop && !push) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (DEPTH=3, DEPTH=4, DEPTH=1 instances).
module tb_pipe_stage_chain;

`ifdef PIPE_STAGE_CHAIN_SKID_EN
   localparam int SKID = 1;
`else
   localparam int SKID = 0;
`endif
   localparam int CAP = 3 + SKID;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        a_iv = 0, a_ir, a_fl = 0, a_ov, a_or = 0;
   logic [31:0] a_id = '0, a_od;
   logic [2:0]  a_occ;
   logic        b_iv = 0, b_ir, b_fl = 0, b_ov, b_or = 0;
   logic [31:0] b_id = '0, b_od;
   logic [2:0]  b_occ;
   logic        c_iv = 0, c_ir, c_fl = 0, c_ov, c_or = 0;
   logic [31:0] c_id = '0, c_od;
   logic [1:0]  c_occ;

   int compared = 0;
   int mismatched = 0;

   pipe_stage_chain #(.WIDTH(32), .DEPTH(3)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
      .in_data(a_id), .flush(a_fl), .out_valid(a_ov),
      .out_ready(a_or), .out_data(a_od), .occupancy(a_occ)
   );
   pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
      .in_data(b_id), .flush(b_fl), .out_valid(b_ov),
      .out_ready(b_or), .out_data(b_od), .occupancy(b_occ)
   );
   pipe_stage_chain #(.WIDTH(32), .DEPTH(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir),
      .in_data(c_id), .flush(c_fl), .out_valid(c_ov),
      .out_ready(c_or), .out_data(c_od), .occupancy(c_occ)
   );

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next();
      next();
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if (a_ov !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_out_valid: got %0b want 0", a_ov);
      end
      compared++;
      if (a_od !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_out_data: got %h want 0", a_od);
      end
      compared++;
      if (a_occ !== 3'd0) begin
         mismatched++;
         $display("FAIL reset_occupancy: got %0d want 0", a_occ);
      end
      compared++;
      if (a_ir !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_in_ready: got %0b want 1", a_ir);
      end
      next();
   endtask

   task automatic test_streaming();
      int occ_exp [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
      logic exp_v;
      a_or = 1'b1;
      for (int c = 0; c < 8; c++) begin
         a_iv = (c < 4);
         a_id = (c < 4) ? 32'(c + 1) : 32'h0;
         @(negedge clk);
         exp_v = (c >= 3 && c <= 6);
         compared++;
         if (a_occ !== 3'(occ_exp[c])) begin
            mismatched++;
            $display("FAIL stream_occ[%0d]: got %0d want %0d", c, a_occ, occ_exp[c]);
         end
         compared++;
         if (a_ov !== exp_v) begin
            mismatched++;
            $display("FAIL stream_valid[%0d]: got %0b want %0b", c, a_ov, exp_v);
         end
         if (exp_v) begin
            compared++;
            if (a_od !== 32'(c - 2)) begin
               mismatched++;
               $display("FAIL stream_data[%0d]: got %h want %h", c, a_od, c - 2);
            end
         end
         if (c < 4) begin
            compared++;
            if (a_ir !== 1'b1) begin
               mismatched++;
               $display("FAIL stream_in_ready[%0d]: got %0b want 1", c, a_ir);
            end
         end
         next();
      end
      a_iv = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] beats [5] = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
      int sent = 0;
      int rcv = 0;
      a_or = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_iv = 1'b1;
         a_id = beats[sent];
         @(negedge clk);
         if (a_ir) sent++;
         next();
      end
      a_iv = 1'b1;
      a_id = beats[sent];
      @(negedge clk);
      compared++;
      if (sent !== CAP) begin
         mismatched++;
         $display("FAIL bp_accepts: got %0d want %0d", sent, CAP);
      end
      compared++;
      if (a_ir !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_in_ready: got %0b want 0", a_ir);
      end
      compared++;
      if (a_occ !== 3'(CAP)) begin
         mismatched++;
         $display("FAIL bp_occ: got %0d want %0d", a_occ, CAP);
      end
      compared++;
      if (a_ov !== 1'b1 || a_od !== 32'h11) begin
         mismatched++;
         $display("FAIL bp_head: got v=%0b d=%h want v=1 d=11", a_ov, a_od);
      end
      next();
      a_or = 1'b1;
      for (int c = 0; c < 20 && rcv < 5; c++) begin
         a_iv = (sent < 5);
         a_id = (sent < 5) ? beats[sent] : 32'h0;
         @(negedge clk);
         if (a_ov) begin
            compared++;
            if (rcv >= 5 || a_od !== beats[rcv]) begin
               mismatched++;
               $display("FAIL bp_drain[%0d]: got %h", rcv, a_od);
            end
            rcv++;
         end
         if (a_iv && a_ir) sent++;
         next();
      end
      a_iv = 1'b0;
      compared++;
      if (rcv !== 5 || sent !== 5) begin
         mismatched++;
         $display("FAIL bp_count: got rcv=%0d sent=%0d want 5/5", rcv, sent);
      end
      @(negedge clk);
      compared++;
      if (a_occ !== 3'd0) begin
         mismatched++;
         $display("FAIL bp_empty_occ: got %0d want 0", a_occ);
      end
      next();
   endtask

   task automatic test_bubble();
      b_or = 1'b0;
      for (int c = 0; c < 6; c++) begin
         b_iv = (c == 0 || c == 3);
         b_id = (c == 0) ? 32'hA : ((c == 3) ? 32'hB : 32'h0);
         @(negedge clk);
         next();
      end
      b_iv = 1'b0;
      b_or = 1'b1;
      @(negedge clk);
      compared++;
      if (b_occ !== 3'd2) begin
         mismatched++;
         $display("FAIL bubble_occ: got %0d want 2", b_occ);
      end
      compared++;
      if (b_ov !== 1'b1 || b_od !== 32'hA) begin
         mismatched++;
         $display("FAIL bubble_head: got v=%0b d=%h want v=1 d=a", b_ov, b_od);
      end
      compared++;
      if (b_ir !== 1'b1) begin
         mismatched++;
         $display("FAIL bubble_in_ready: got %0b want 1", b_ir);
      end
      next();
      b_or = 1'b0;
      @(negedge clk);
      compared++;
      if (b_ov !== 1'b1 || b_od !== 32'hB) begin
         mismatched++;
         $display("FAIL bubble_second: got v=%0b d=%h want v=1 d=b", b_ov, b_od);
      end
      compared++;
      if (b_occ !== 3'd1) begin
         mismatched++;
         $display("FAIL bubble_occ2: got %0d want 1", b_occ);
      end
      next();
      b_or = 1'b1;
      next();
      b_or = 1'b0;
   endtask

   task automatic test_flush();
      int seen = 0;
      a_or = 1'b0;
      for (int c = 0; c < 3; c++) begin
         a_iv = 1'b1;
         a_id = 32'h41 + 32'(c);
         next();
      end
      a_fl = 1'b1;
      a_iv = 1'b1;
      a_id = 32'h99;
      a_or = 1'b1;
      @(negedge clk);
      compared++;
      if (a_ir !== 1'b0 || a_ov !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_gate: got ir=%0b ov=%0b want 0/0", a_ir, a_ov);
      end
      compared++;
      if (a_occ !== 3'd3) begin
         mismatched++;
         $display("FAIL flush_pre_occ: got %0d want 3", a_occ);
      end
      next();
      a_fl = 1'b0;
      a_iv = 1'b0;
      @(negedge clk);
      compared++;
      if (a_ov !== 1'b0 || a_occ !== 3'd0 || a_ir !== 1'b1) begin
         mismatched++;
         $display("FAIL flush_after: got ov=%0b occ=%0d ir=%0b want 0/0/1", a_ov, a_occ, a_ir);
      end
      for (int c = 0; c < 4; c++) begin
         next();
         @(negedge clk);
         if (a_ov) seen++;
      end
      compared++;
      if (seen !== 0) begin
         mismatched++;
         $display("FAIL flush_leak: got %0d beats want 0", seen);
      end
      next();
   endtask

   task automatic test_reset_mid();
      a_or = 1'b1;
      for (int c = 0; c < 2; c++) begin
         a_iv = 1'b1;
         a_id = 32'h21 + 32'(c);
         next();
      end
      a_iv = 1'b0;
      rst = 1'b1;
      next();
      rst = 1'b0;
      a_iv = 1'b1;
      a_id = 32'h33;
      @(negedge clk);
      compared++;
      if (a_ov !== 1'b0 || a_od !== 32'h0 || a_occ !== 3'd0) begin
         mismatched++;
         $display("FAIL rstmid_state: got ov=%0b od=%h occ=%0d want 0/0/0", a_ov, a_od, a_occ);
      end
      next();
      a_iv = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         compared++;
         if (a_ov !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_early[%0d]: got %0b want 0", c, a_ov);
         end
         next();
      end
      @(negedge clk);
      compared++;
      if (a_ov !== 1'b1 || a_od !== 32'h33) begin
         mismatched++;
         $display("FAIL rstmid_emerge: got v=%0b d=%h want v=1 d=33", a_ov, a_od);
      end
      next();
   endtask

   task automatic test_skid();
      c_or = 1'b0;
      c_iv = 1'b1;
      c_id = 32'h51;
      next();
      c_id = 32'h52;
      @(negedge clk);
      compared++;
      if (c_ir !== 1'b1) begin
         mismatched++;
         $display("FAIL skid_accept: got %0b want 1", c_ir);
      end
      next();
      c_iv = 1'b0;
      c_or = 1'b1;
      @(negedge clk);
      compared++;
      if (c_occ !== 2'd2 || c_ir !== 1'b0) begin
         mismatched++;
         $display("FAIL skid_full: got occ=%0d ir=%0b want 2/0", c_occ, c_ir);
      end
      compared++;
      if (c_ov !== 1'b1 || c_od !== 32'h51) begin
         mismatched++;
         $display("FAIL skid_first: got v=%0b d=%h want v=1 d=51", c_ov, c_od);
      end
      next();
      @(negedge clk);
      compared++;
      if (c_ov !== 1'b1 || c_od !== 32'h52) begin
         mismatched++;
         $display("FAIL skid_second: got v=%0b d=%h want v=1 d=52", c_ov, c_od);
      end
      next();
      c_or = 1'b0;
      @(negedge clk);
      compared++;
      if (c_ov !== 1'b0 || c_occ !== 2'd0) begin
         mismatched++;
         $display("FAIL skid_empty: got v=%0b occ=%0d want 0/0", c_ov, c_occ);
      end
      next();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_reset_mid();
`ifdef PIPE_STAGE_CHAIN_SKID_EN
      test_skid();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
